muldiv_sequencer: RTL and testbench

//  Sequences the shared iterative mult_div unit for MULT/MULTU/DIV/DIVU.

---
 rtl/muldiv_sequencer_pkg.sv | 20 ++
 rtl/muldiv_cycle_counter.sv | 30 +++
 rtl/muldiv_sequencer.sv | 91 +++++++++
 tb/tb_muldiv_sequencer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the mult/div sequencer: state encodings, op codes
// and default latencies.
package muldiv_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_WRITE = 3'd3,
    ST_EXC   = 3'd4
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int DEF_MULT_LAT = 32;
  localparam int DEF_DIV_LAT  = 32;
  localparam int DEF_CNT_W    = 6;

endpackage

// File: rtl/muldiv_cycle_counter.sv
// Loadable down-counter timing the RUN phase; clear beats load beats enable.
module muldiv_cycle_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             enable,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the shared iterative mult_div unit: clear, timed run, then a
// single Hi/Lo write or a divide-by-zero exception.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             flush,
  input  logic             div_zero,
  output logic             mult_div_control,
  output logic             unit_reset,
  output logic             load_regHi,
  output logic             load_regLo,
  output logic             busy,
  output logic             done,
  output logic             div_zero_exc,
  output logic [CNT_W-1:0] cycles_left
);

  state_t           state, state_next;
  logic             op_q;
  logic             first_run_q;
  logic             cnt_clear, cnt_load, cnt_enable, cnt_zero;
  logic [CNT_W-1:0] cnt_value, cnt_load_value;
  logic             accept;

  assign accept = (state == ST_IDLE) && start && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      op_q        <= OP_MULT;
      first_run_q <= 1'b0;
    end else begin
      state       <= state_next;
      first_run_q <= (state == ST_CLEAR) && !flush;
      if (accept) op_q <= op;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (start) state_next = ST_CLEAR;
      ST_CLEAR: state_next = ST_RUN;
      ST_RUN: begin
        // div_zero only counts on the first RUN cycle; later the unit's flag is stale.
        if (first_run_q && op_q == OP_DIV && div_zero) state_next = ST_EXC;
        else if (cnt_zero)                            state_next = ST_WRITE;
      end
      ST_WRITE: state_next = ST_IDLE;
      ST_EXC:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  assign cnt_load_value = (op_q == OP_DIV) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
  assign cnt_clear      = flush || (state == ST_RUN && state_next == ST_EXC);
  assign cnt_load       = (state == ST_CLEAR);
  assign cnt_enable     = (state == ST_RUN) && !cnt_zero;

  muldiv_cycle_counter #(.CNT_W(CNT_W)) u_counter (
    .clk        (clk),
    .reset      (reset),
    .clear      (cnt_clear),
    .load       (cnt_load),
    .enable     (cnt_enable),
    .load_value (cnt_load_value),
    .count      (cnt_value),
    .zero       (cnt_zero)
  );

  // Moore decode: outputs depend on registered state only.
  assign mult_div_control = op_q;
  assign unit_reset       = (state == ST_CLEAR);
  assign load_regHi       = (state == ST_WRITE);
  assign load_regLo       = (state == ST_WRITE);
  assign done             = (state == ST_WRITE);
  assign div_zero_exc     = (state == ST_EXC);
  assign busy             = (state != ST_IDLE);
  assign cycles_left      = (state == ST_RUN) ? cnt_value : '0;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: reset, mult, div-by-zero, start while
// busy, flush and mid-operation async reset.
module tb_muldiv_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, op, flush, div_zero;
  logic       mult_div_control, unit_reset, load_regHi, load_regLo;
  logic       busy, done, div_zero_exc;
  logic [5:0] cycles_left;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.MULT_LAT(32), .DIV_LAT(32), .CNT_W(6)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .op               (op),
    .flush            (flush),
    .div_zero         (div_zero),
    .mult_div_control (mult_div_control),
    .unit_reset       (unit_reset),
    .load_regHi       (load_regHi),
    .load_regLo       (load_regLo),
    .busy             (busy),
    .done             (done),
    .div_zero_exc     (div_zero_exc),
    .cycles_left      (cycles_left)
  );

  // {mult_div_control, unit_reset, load_regHi, load_regLo, busy, done, div_zero_exc}
  function automatic logic [6:0] outs();
    return {mult_div_control, unit_reset, load_regHi, load_regLo, busy, done, div_zero_exc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to the next cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Mult started in cycle 0; optional second start in cycle `extra` (negative = none).
  task automatic run_mult(input string name, input int extra);
    int dones = 0;
    start = 1'b1; op = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      next_cycle();
      start = (c == extra);
      op    = (c == extra);
      if (done) dones++;
      chk($sformatf("%s outs c%0d", name, c), 32'(outs()),
          32'({1'b0, c == 1, c == 34, c == 34, c >= 1 && c <= 34, c == 34, 1'b0}));
      chk($sformatf("%s cycles_left c%0d", name, c), 32'(cycles_left),
          (c >= 2 && c <= 33) ? 32'(33 - c) : 32'd0);
    end
    start = 1'b0; op = 1'b0;
    chk({name, " done count"}, 32'(dones), 32'd1);
  endtask

  initial begin
    logic [6:0] any_out;

    // 1. Reset held low for 3 cycles with start asserted.
    reset = 1'b0; start = 1'b1; op = 1'b1; flush = 1'b0; div_zero = 1'b0;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      chk("reset outs", 32'(outs()), 32'd0);
      chk("reset cycles_left", 32'(cycles_left), 32'd0);
    end
    reset = 1'b1; start = 1'b0; op = 1'b0;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      chk("post-reset idle", 32'(outs()), 32'd0);
    end

    // flush and start together in IDLE: start is dropped.
    start = 1'b1; op = 1'b1; flush = 1'b1;
    next_cycle();
    start = 1'b0; op = 1'b0; flush = 1'b0;
    chk("flush beats start", 32'(outs()), 32'd0);
    next_cycle();
    chk("flush beats start later", 32'(outs()), 32'd0);

    // 2. Plain multiply.
    run_mult("mult", -1);
    next_cycle();

    // 4. Start (with op=div) while busy in cycle 10 is ignored.
    run_mult("busy_start", 10);
    next_cycle();

    // 3. Divide by zero flagged in the first RUN cycle.
    start = 1'b1; op = 1'b1;
    next_cycle();                                   // cycle 1
    start = 1'b0; op = 1'b0;
    chk("dz c1 outs", 32'(outs()), 32'b1100100);
    next_cycle();                                   // cycle 2
    div_zero = 1'b1;
    chk("dz c2 outs", 32'(outs()), 32'b1000100);
    chk("dz c2 cycles_left", 32'(cycles_left), 32'd31);
    next_cycle();                                   // cycle 3
    div_zero = 1'b0;
    chk("dz c3 outs", 32'(outs()), 32'b1000101);
    next_cycle();                                   // cycle 4
    chk("dz c4 outs", 32'(outs()), 32'b1000000);

    // 5. Flush in cycle 15 of a divide; new mult accepted in cycle 16.
    any_out = '0;
    start = 1'b1; op = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      next_cycle();
      start = 1'b0; op = 1'b0;
      flush = (c == 15);
      any_out |= {4'b0, load_regHi | load_regLo, done, div_zero_exc};
      if (c == 14) chk("flush c14 cycles_left", 32'(cycles_left), 32'd19);
    end
    chk("flush no load/done/exc", 32'(any_out), 32'd0);
    chk("flush c16 outs", 32'(outs()), 32'b1000000);
    chk("flush c16 cycles_left", 32'(cycles_left), 32'd0);
    start = 1'b1; op = 1'b0;
    next_cycle();                                   // new op cycle 1
    start = 1'b0;
    chk("restart c1 outs", 32'(outs()), 32'b0100100);

    // 6. Async reset in cycle 20 of that mult.
    for (int c = 2; c <= 20; c++) next_cycle();
    chk("pre-reset busy", 32'(busy), 32'd1);
    chk("pre-reset cycles_left", 32'(cycles_left), 32'd13);
    reset = 1'b0;
    #1;
    chk("async reset outs", 32'(outs()), 32'd0);
    chk("async reset cycles_left", 32'(cycles_left), 32'd0);
    any_out = '0;
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      any_out |= outs();
    end
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      any_out |= outs();
    end
    chk("after reset quiet", 32'(any_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
